ras_ctrl: RTL and testbench

//  Initiator/controller for the 2-write-port, checkpointed return-address-stack RAM in fetch.

---
 rtl/ras_ctrl_pkg.sv | 21 ++
 rtl/ras_ptr_unit.sv | 69 ++++++
 rtl/ras_ctrl.sv | 151 +++++++++++++++
 tb/tb_ras_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ras_ctrl_pkg.sv
// Shared constants and types for the return-address-stack controller.
package ras_ctrl_pkg;

  localparam int RAS_DEPTH  = 16;
  localparam int RAS_INDEX  = 4;
  localparam int ADDR_WIDTH = 32;
  // Occupancy counts range 0..RAS_DEPTH inclusive, hence one extra bit.
  localparam int CNT_WIDTH  = RAS_INDEX + 1;

  typedef logic [RAS_INDEX-1:0] ras_ptr_t;
  typedef logic [CNT_WIDTH-1:0] ras_cnt_t;

  typedef struct packed {
    ras_ptr_t                addr;
    logic [ADDR_WIDTH-1:0]   data;
  } ras_wr_t;

  localparam ras_ptr_t TOS_RESET = ras_ptr_t'(RAS_DEPTH - 1);
  localparam ras_cnt_t CNT_FULL  = ras_cnt_t'(RAS_DEPTH);

endpackage

// File: rtl/ras_ptr_unit.sv
// Top-of-stack pointer and saturating occupancy count for one RAS view.
// Push/pop/push+pop update rules, wrap-around and an override load used to
// restore the speculative view from the architectural one.
module ras_ptr_unit
  import ras_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic                 load_i,
  input  logic [RAS_INDEX-1:0] load_tos_i,
  input  logic [CNT_WIDTH-1:0] load_cnt_i,
  output logic [RAS_INDEX-1:0] tos_o,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic [RAS_INDEX-1:0] tos_next_o,
  output logic [CNT_WIDTH-1:0] cnt_next_o,
  output logic                 we_o,
  output logic [RAS_INDEX-1:0] wr_addr_o,
  output logic                 pop_ok_o
);

  ras_ptr_t tos_q, tos_d;
  ras_cnt_t cnt_q, cnt_d;

  // Next pointer/count and RAM write request for this cycle's operation.
  always_comb begin
    tos_d     = tos_q;
    cnt_d     = cnt_q;
    we_o      = 1'b0;
    wr_addr_o = tos_q + 1'b1;
    pop_ok_o  = pop_i && (cnt_q != '0);
    if (push_i && pop_i) begin
      // Pop consumes the current TOS, push replaces it in place.
      we_o      = 1'b1;
      wr_addr_o = tos_q;
      if (cnt_q == '0) cnt_d = ras_cnt_t'(1);
    end else if (push_i) begin
      // When full, the wrapped pointer lands on the oldest entry.
      we_o      = 1'b1;
      wr_addr_o = tos_q + 1'b1;
      tos_d     = tos_q + 1'b1;
      if (cnt_q != CNT_FULL) cnt_d = cnt_q + 1'b1;
    end else if (pop_ok_o) begin
      tos_d = tos_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Pointer/count registers; load overrides the normal update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tos_q <= TOS_RESET;
      cnt_q <= '0;
    end else if (load_i) begin
      tos_q <= load_tos_i;
      cnt_q <= load_cnt_i;
    end else begin
      tos_q <= tos_d;
      cnt_q <= cnt_d;
    end
  end

  assign tos_o      = tos_q;
  assign cnt_o      = cnt_q;
  assign tos_next_o = tos_d;
  assign cnt_next_o = cnt_d;

endmodule

// File: rtl/ras_ctrl.sv
// Return-address-stack controller: speculative and architectural pointers,
// RAM port drive, one-entry hold buffer for the commit-write/recover collision,
// and the registered predicted return target.
module ras_ctrl
  import ras_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push_i,
  input  logic [ADDR_WIDTH-1:0] pushAddr_i,
  input  logic                  pop_i,
  input  logic                  commitPush_i,
  input  logic [ADDR_WIDTH-1:0] commitAddr_i,
  input  logic                  commitPop_i,
  input  logic                  recover_i,
  output logic [ADDR_WIDTH-1:0] target_o,
  output logic                  targetValid_o,
  output logic [RAS_INDEX-1:0]  ramRdAddr_o,
  input  logic [ADDR_WIDTH-1:0] ramRdData_i,
  output logic [RAS_INDEX-1:0]  ramWrAddr0_o,
  output logic [ADDR_WIDTH-1:0] ramWrData0_o,
  output logic                  ramWe0_o,
  output logic [RAS_INDEX-1:0]  ramWrAddr1_o,
  output logic [ADDR_WIDTH-1:0] ramWrData1_o,
  output logic                  ramWe1_o,
  output logic                  ramRecover_o
);

  // Fetch operations are discarded in a recover cycle.
  logic fetch_push, fetch_pop;
  assign fetch_push = push_i & ~recover_i;
  assign fetch_pop  = pop_i  & ~recover_i;

  ras_ptr_t spec_tos, spec_tos_next, spec_wr_addr;
  ras_cnt_t spec_cnt, spec_cnt_next;
  logic     spec_we, spec_pop_ok;

  ras_ptr_t arch_tos, arch_tos_next, arch_wr_addr;
  ras_cnt_t arch_cnt, arch_cnt_next;
  logic     arch_we, arch_pop_ok;

  ras_ptr_unit u_arch (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (commitPush_i),
    .pop_i      (commitPop_i),
    .load_i     (1'b0),
    .load_tos_i ('0),
    .load_cnt_i ('0),
    .tos_o      (arch_tos),
    .cnt_o      (arch_cnt),
    .tos_next_o (arch_tos_next),
    .cnt_next_o (arch_cnt_next),
    .we_o       (arch_we),
    .wr_addr_o  (arch_wr_addr),
    .pop_ok_o   (arch_pop_ok)
  );

  // Recover restores speculative state from the post-commit architectural state.
  ras_ptr_unit u_spec (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (fetch_push),
    .pop_i      (fetch_pop),
    .load_i     (recover_i),
    .load_tos_i (arch_tos_next),
    .load_cnt_i (arch_cnt_next),
    .tos_o      (spec_tos),
    .cnt_o      (spec_cnt),
    .tos_next_o (spec_tos_next),
    .cnt_next_o (spec_cnt_next),
    .we_o       (spec_we),
    .wr_addr_o  (spec_wr_addr),
    .pop_ok_o   (spec_pop_ok)
  );

  assign ramRdAddr_o  = spec_tos;
  assign ramWe0_o     = spec_we;
  assign ramWrAddr0_o = spec_wr_addr;
  assign ramWrData0_o = pushAddr_i;
  assign ramRecover_o = recover_i;

  ras_wr_t hold_q, hold_d;
  logic    hold_valid_q, hold_valid_d;
  ras_wr_t arch_req, wr1;
  logic    we1;

  // Port-1 arbitration: the RAM ignores we1 during recover, so a commit push
  // in that cycle parks in the hold buffer; a held entry always drains first
  // and a commit arriving while it drains takes its place.
  always_comb begin
    arch_req.addr = arch_wr_addr;
    arch_req.data = commitAddr_i;
    we1           = 1'b0;
    wr1           = arch_req;
    hold_valid_d  = hold_valid_q;
    hold_d        = hold_q;
    if (recover_i) begin
      if (arch_we) begin
        hold_valid_d = 1'b1;
        hold_d       = arch_req;
      end
    end else if (hold_valid_q) begin
      we1          = 1'b1;
      wr1          = hold_q;
      hold_valid_d = arch_we;
      if (arch_we) hold_d = arch_req;
    end else begin
      we1 = arch_we;
    end
  end

  assign ramWe1_o     = we1;
  assign ramWrAddr1_o = wr1.addr;
  assign ramWrData1_o = wr1.data;

  // Hold buffer register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
    end
  end

  // A held entry is not yet in the RAM, so pops of its address read the buffer.
  logic                  bypass;
  logic [ADDR_WIDTH-1:0] pop_data;
  assign bypass   = hold_valid_q && (hold_q.addr == spec_tos);
  assign pop_data = bypass ? hold_q.data : ramRdData_i;

  logic [ADDR_WIDTH-1:0] target_q;
  logic                  target_valid_q;

  // Registered predicted target; valid pulses for one cycle per non-empty pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      target_q       <= '0;
      target_valid_q <= 1'b0;
    end else begin
      target_valid_q <= fetch_pop & spec_pop_ok;
      if (fetch_pop) target_q <= pop_data;
    end
  end

  assign target_o      = target_q;
  assign targetValid_o = target_valid_q;

endmodule

// File: tb/tb_ras_ctrl.sv
// Bench for ras_ctrl with a behavioural checkpointed 2-write-port RAS RAM.
// Handshake: targetValid_o is a one-cycle pulse; each pulse consumes exactly
// one expected target from exp_q, and a pulse with nothing expected is an error.
module tb_ras_ctrl;
  import ras_ctrl_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  push_i, pop_i, commitPush_i, commitPop_i, recover_i;
  logic [ADDR_WIDTH-1:0] pushAddr_i, commitAddr_i;
  logic [ADDR_WIDTH-1:0] target_o;
  logic                  targetValid_o;
  logic [RAS_INDEX-1:0]  ramRdAddr_o, ramWrAddr0_o, ramWrAddr1_o;
  logic [ADDR_WIDTH-1:0] ramRdData_i, ramWrData0_o, ramWrData1_o;
  logic                  ramWe0_o, ramWe1_o, ramRecover_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [ADDR_WIDTH-1:0] exp_q[$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- RAM model ----------------
  logic [ADDR_WIDTH-1:0] ram_mem  [RAS_DEPTH];
  logic [ADDR_WIDTH-1:0] ram_ckpt [RAS_DEPTH];

  assign ramRdData_i = ram_mem[ramRdAddr_o];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ram_mem[i]  <= '0;
        ram_ckpt[i] <= '0;
      end
    end else if (ramRecover_o) begin
      for (int i = 0; i < RAS_DEPTH; i++) ram_mem[i] <= ram_ckpt[i];
    end else begin
      if (ramWe0_o) ram_mem[ramWrAddr0_o] <= ramWrData0_o;
      if (ramWe1_o) begin
        ram_mem[ramWrAddr1_o]  <= ramWrData1_o;
        ram_ckpt[ramWrAddr1_o] <= ramWrData1_o;
      end
    end
  end

  // ---------------- DUT ----------------
  ras_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .push_i        (push_i),
    .pushAddr_i    (pushAddr_i),
    .pop_i         (pop_i),
    .commitPush_i  (commitPush_i),
    .commitAddr_i  (commitAddr_i),
    .commitPop_i   (commitPop_i),
    .recover_i     (recover_i),
    .target_o      (target_o),
    .targetValid_o (targetValid_o),
    .ramRdAddr_o   (ramRdAddr_o),
    .ramRdData_i   (ramRdData_i),
    .ramWrAddr0_o  (ramWrAddr0_o),
    .ramWrData0_o  (ramWrData0_o),
    .ramWe0_o      (ramWe0_o),
    .ramWrAddr1_o  (ramWrAddr1_o),
    .ramWrData1_o  (ramWrData1_o),
    .ramWe1_o      (ramWe1_o),
    .ramRecover_o  (ramRecover_o)
  );

  // Upstream never asserts recover in two consecutive cycles.
  assert property (@(posedge clk) disable iff (!reset_n) recover_i |=> !recover_i)
    else $error("recover_i asserted on consecutive cycles");

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (reset_n === 1'b1 && targetValid_o === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL target_unexpected: got valid target 0x%0h, required no valid target", target_o);
      end else begin
        logic [ADDR_WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (target_o !== e) begin
          n_fail++;
          $display("FAIL target: got 0x%0h, required 0x%0h", target_o, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic p, input logic [31:0] pa, input logic po,
                       input logic cp, input logic [31:0] ca, input logic cpo,
                       input logic rec);
    @(posedge clk);
    #1;
    push_i       = p;
    pushAddr_i   = pa;
    pop_i        = po;
    commitPush_i = cp;
    commitAddr_i = ca;
    commitPop_i  = cpo;
    recover_i    = rec;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic zero_inputs();
    push_i = 1'b0; pushAddr_i = '0; pop_i = 1'b0;
    commitPush_i = 1'b0; commitAddr_i = '0; commitPop_i = 1'b0; recover_i = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    zero_inputs();
    exp_q.delete();
    #10;
    reset_n = 1'b1;
  endtask

  task automatic check_empty(input string name);
    idle();
    idle();
    chk(name, exp_q.size(), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, required end of stimulus");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    zero_inputs();
    #12;
    reset_n = 1'b1;

    // Test 1: basic push/pop and underflow
    do_reset();
    #2;
    chk("reset_target", target_o, 0);
    chk("reset_valid", targetValid_o, 0);
    chk("reset_rdaddr", ramRdAddr_o, 15);
    chk("reset_we0", ramWe0_o, 0);
    chk("reset_we1", ramWe1_o, 0);
    drive(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    chk("push1_we0", ramWe0_o, 1);
    chk("push1_addr0", ramWrAddr0_o, 0);
    chk("push1_data0", ramWrData0_o, 32'h100);
    drive(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    chk("push2_addr0", ramWrAddr0_o, 1);
    exp_q.push_back(32'h200);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    exp_q.push_back(32'h100);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    chk("underflow_rdaddr", ramRdAddr_o, 15);
    check_empty("t1_drain");

    // Test 2: 17 pushes wrap and saturate; 16 pops then underflow
    do_reset();
    for (int i = 1; i <= 17; i++) drive(1'b1, 32'(i), 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    idle();
    #2;
    chk("wrap_rdaddr", ramRdAddr_o, 0);
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back(32'(32'h11 - k));
      drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    check_empty("t2_drain");

    // Test 3: push and pop in the same cycle
    do_reset();
    drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    exp_q.push_back(32'h40);
    drive(1'b1, 32'h80, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    chk("pushpop_we0", ramWe0_o, 1);
    chk("pushpop_addr0", ramWrAddr0_o, 0);
    chk("pushpop_data0", ramWrData0_o, 32'h80);
    exp_q.push_back(32'h80);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    #2;
    chk("pushpop_tos_kept", ramRdAddr_o, 0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    check_empty("t3_drain");

    // Test 4: recover restores speculative state from architectural state
    do_reset();
    drive(1'b1, 32'hA, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'hB, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hA, 1'b0, 1'b0);
    #2;
    chk("commit_we1", ramWe1_o, 1);
    chk("commit_addr1", ramWrAddr1_o, 0);
    chk("commit_data1", ramWrData1_o, 32'hA);
    chk("prerecover_rdaddr", ramRdAddr_o, 1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    #2;
    chk("recover_flag", ramRecover_o, 1);
    idle();
    #2;
    chk("recover_rdaddr", ramRdAddr_o, 0);
    chk("recover_flag_low", ramRecover_o, 0);
    exp_q.push_back(32'hA);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    check_empty("t4_drain");

    // Test 5: recover/commit collision, hold drain, bypass, chained hold
    do_reset();
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hC0, 1'b0, 1'b1);
    #2;
    chk("collide_we1", ramWe1_o, 0);
    chk("collide_recover", ramRecover_o, 1);
    exp_q.push_back(32'hC0);
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'hD0, 1'b0, 1'b0);
    #2;
    chk("drain_we1", ramWe1_o, 1);
    chk("drain_addr1", ramWrAddr1_o, 0);
    chk("drain_data1", ramWrData1_o, 32'hC0);
    chk("drain_rdaddr", ramRdAddr_o, 0);
    idle();
    #2;
    chk("chain_we1", ramWe1_o, 1);
    chk("chain_addr1", ramWrAddr1_o, 1);
    chk("chain_data1", ramWrData1_o, 32'hD0);
    idle();
    #2;
    chk("hold_empty_we1", ramWe1_o, 0);
    check_empty("t5_drain");

    // Test 6: asynchronous reset between edges
    do_reset();
    drive(1'b1, 32'h55, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b1, 32'h66, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    zero_inputs();
    #1;
    chk("prereset_valid", targetValid_o, 1);
    chk("prereset_target", target_o, 32'h66);
    reset_n = 1'b0;
    #1;
    chk("async_target", target_o, 0);
    chk("async_valid", targetValid_o, 0);
    chk("async_rdaddr", ramRdAddr_o, 15);
    #8;
    reset_n = 1'b1;
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    check_empty("t6_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
